// File: rtl/branch_ctrl_seq_if.sv
// Connection bundle between the branch sequencer and the datapath it drives:
// run/IR/bus inputs, the per-state control strobes and the status outputs.
interface branch_ctrl_seq_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic [31:0]      ir;
  logic [31:0]      bus_in;
  logic             PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin;
  logic             MDRout, IRin, Gra, Rout, con_in, Yin, Cout, ADD;
  logic             con_ff;
  logic             illegal;
  logic             busy;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    input  run, ir, bus_in,
    output PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin,
           MDRout, IRin, Gra, Rout, con_in, Yin, Cout, ADD,
           con_ff, illegal, busy, taken_cnt
  );

  modport slave (
    output run, ir, bus_in,
    input  PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin,
           MDRout, IRin, Gra, Rout, con_in, Yin, Cout, ADD,
           con_ff, illegal, busy, taken_cnt
  );
endinterface

// File: rtl/branch_ctrl_seq.sv
// Moore sequencer stepping the datapath through T0..T6 for conditional
// branches; holds the CON flip-flop and a saturating taken-branch counter.
module branch_ctrl_seq #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  branch_ctrl_seq_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_t;

  localparam logic [3:0]       WAIT_LIM = 4'(MEM_WAIT);
  localparam logic [4:0]       BR_OP    = 5'b10010;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic             con_q, con_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_branch_s;
  logic [15:0]      strb_s;
  logic             illegal_s;

  function automatic logic cond_eval(input logic [3:0] c2, input logic [31:0] v);
    logic r;
    case (c2)
      4'b0000: r = (v == 32'd0);
      4'b0001: r = (v != 32'd0);
      4'b0010: r = ~v[31];
      4'b0011: r = v[31];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign is_branch_s = (bus.ir[31:27] == BR_OP);

  // Next-state, wait counter, CON latch and taken counter
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    con_d   = con_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.run) state_d = T0;
        else         state_d = IDLE;
      end
      T0: begin
        state_d = T1;
        wait_d  = 4'd0;
      end
      T1: begin
        if (wait_q == WAIT_LIM) begin
          state_d = T2;
          wait_d  = 4'd0;
        end else begin
          wait_d  = wait_q + 4'd1;
        end
      end
      T2: state_d = T3;
      T3: begin
        if (is_branch_s) begin
          con_d   = cond_eval(bus.ir[22:19], bus.bus_in);
          state_d = T4;
        end else begin
          state_d = IDLE;
        end
      end
      T4: state_d = T5;
      T5: state_d = T6;
      T6: begin
        if (con_q && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
        else                             cnt_d = cnt_q;
        if (bus.run) state_d = T0;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and status registers; reset clears everything at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
      con_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      con_q   <= con_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobe decode; bit order matches the concatenation assigned below
  always_comb begin
    strb_s    = 16'h0000;
    illegal_s = 1'b0;
    case (state_q)
      IDLE: strb_s = 16'h0000;
      T0:   strb_s = 16'hF000;
      T1:   strb_s = 16'h0F00;
      T2:   strb_s = 16'h00C0;
      T3: begin
        if (is_branch_s) strb_s    = 16'h0038;
        else             illegal_s = 1'b1;
      end
      T4:   strb_s = 16'h8004;
      T5:   strb_s = 16'h1003;
      T6:   strb_s = {4'b0000, 1'b1, con_q, 10'b0000000000};
      default: strb_s = 16'h0000;
    endcase
  end

  assign {bus.PCout, bus.MARin, bus.IncPC, bus.Zlowin,
          bus.Zlowout, bus.PCin, bus.Read, bus.MDRin,
          bus.MDRout, bus.IRin, bus.Gra, bus.Rout,
          bus.con_in, bus.Yin, bus.Cout, bus.ADD} = strb_s;

  assign bus.illegal   = illegal_s;
  assign bus.busy      = (state_q != IDLE);
  assign bus.con_ff    = con_q;
  assign bus.taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_ctrl_seq.sv
// Directed bench: a branch vector table on a zero-wait sequencer, plus
// hand-written wait-state, back-to-back, saturation, illegal and reset cases.
module tb_branch_ctrl_seq;

  logic clock = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_cnt0 = 0;

  always #5 clock = ~clock;

  branch_ctrl_seq_if #(.CNT_W(16)) if0 ();
  branch_ctrl_seq_if #(.CNT_W(2))  if1 ();

  branch_ctrl_seq #(.MEM_WAIT(0), .CNT_W(16)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(if0.master));
  branch_ctrl_seq #(.MEM_WAIT(2), .CNT_W(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(if1.master));

  wire [15:0] s0 = {if0.PCout, if0.MARin, if0.IncPC, if0.Zlowin, if0.Zlowout, if0.PCin,
                    if0.Read, if0.MDRin, if0.MDRout, if0.IRin, if0.Gra, if0.Rout,
                    if0.con_in, if0.Yin, if0.Cout, if0.ADD};
  wire [15:0] s1 = {if1.PCout, if1.MARin, if1.IncPC, if1.Zlowin, if1.Zlowout, if1.PCin,
                    if1.Read, if1.MDRin, if1.MDRout, if1.IRin, if1.Gra, if1.Rout,
                    if1.con_in, if1.Yin, if1.Cout, if1.ADD};

  typedef struct {
    string       nm;
    logic [31:0] ir;
    logic [31:0] bus;
    logic        taken;
  } vec_t;

  vec_t vt [9];
  logic [15:0] exp_seq [9] = '{16'hF000, 16'h0F00, 16'h0F00, 16'h0F00, 16'h00C0,
                               16'h0038, 16'h8004, 16'h1003, 16'h0C00};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    if0.run = 1'b1; if0.ir = v.ir; if0.bus_in = v.bus;
    step(); chk({v.nm, " T0"}, {16'd0, s0}, 32'h0000F000); chk({v.nm, " busy"}, {31'd0, if0.busy}, 32'd1);
    if0.run = 1'b0;
    step(); chk({v.nm, " T1"}, {16'd0, s0}, 32'h00000F00);
    step(); chk({v.nm, " T2"}, {16'd0, s0}, 32'h000000C0);
    step(); chk({v.nm, " T3"}, {16'd0, s0}, 32'h00000038);
    step(); chk({v.nm, " T4"}, {16'd0, s0}, 32'h00008004);
    chk({v.nm, " con_ff"}, {31'd0, if0.con_ff}, {31'd0, v.taken});
    step(); chk({v.nm, " T5"}, {16'd0, s0}, 32'h00001003);
    step(); chk({v.nm, " T6"}, {16'd0, s0}, v.taken ? 32'h00000C00 : 32'h00000800);
    if (v.taken) exp_cnt0++;
    step(); chk({v.nm, " idle"}, {16'd0, s0}, 32'd0); chk({v.nm, " idle busy"}, {31'd0, if0.busy}, 32'd0);
    chk({v.nm, " taken_cnt"}, {16'd0, if0.taken_cnt}, exp_cnt0);
  endtask

  initial begin
    vt[0] = '{"brpl_pos",   32'h91100023, 32'h00000005, 1'b1};
    vt[1] = '{"brpl_neg",   32'h91100023, 32'h80000000, 1'b0};
    vt[2] = '{"brzr_zero",  32'h91000000, 32'h00000000, 1'b1};
    vt[3] = '{"brnz_zero",  32'h91080000, 32'h00000000, 1'b0};
    vt[4] = '{"c2_0111",    32'h91380000, 32'h00000000, 1'b0};
    vt[5] = '{"brzr_one",   32'h91000000, 32'h00000001, 1'b0};
    vt[6] = '{"brmi_pos",   32'h91180000, 32'h00000001, 1'b0};
    vt[7] = '{"brnz_seven", 32'h91080000, 32'h00000007, 1'b1};
    vt[8] = '{"brmi_neg",   32'h91180000, 32'h80000000, 1'b1};

    reset_n = 1'b0;
    if0.run = 1'b0; if0.ir = 32'd0; if0.bus_in = 32'd0;
    if1.run = 1'b0; if1.ir = 32'd0; if1.bus_in = 32'd0;
    step(); step();
    chk("reset strobes", {16'd0, s0}, 32'd0);
    chk("reset busy", {31'd0, if0.busy}, 32'd0);
    chk("reset con_ff", {31'd0, if0.con_ff}, 32'd0);
    chk("reset taken_cnt", {16'd0, if0.taken_cnt}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("idle no run", {16'd0, s0}, 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    // non-branch opcode: single-cycle illegal, back to IDLE, CON untouched
    if0.run = 1'b1; if0.ir = 32'h08000000; if0.bus_in = 32'd0;
    step(); if0.run = 1'b0;
    step(); step(); step();
    chk("illegal T3 strobes", {16'd0, s0}, 32'd0);
    chk("illegal pulse", {31'd0, if0.illegal}, 32'd1);
    chk("illegal con_in", {31'd0, if0.con_in}, 32'd0);
    step();
    chk("illegal gone", {31'd0, if0.illegal}, 32'd0);
    chk("illegal busy", {31'd0, if0.busy}, 32'd0);
    chk("illegal con_ff kept", {31'd0, if0.con_ff}, 32'd1);
    chk("illegal cnt kept", {16'd0, if0.taken_cnt}, exp_cnt0);

    // MEM_WAIT=2 back-to-back, five taken branches into a 2-bit counter
    if1.run = 1'b1; if1.ir = 32'h91100023; if1.bus_in = 32'h00000005;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 9; c++) begin
        step();
        chk($sformatf("b2b k%0d c%0d", k, c), {16'd0, s1}, {16'd0, exp_seq[c]});
        if (c == 0 && k > 0) chk($sformatf("sat cnt k%0d", k), {30'd0, if1.taken_cnt}, (k > 3) ? 32'd3 : k);
        if (c == 0 && k == 4) if1.run = 1'b0;
      end
    end
    step();
    chk("b2b idle busy", {31'd0, if1.busy}, 32'd0);
    chk("sat cnt final", {30'd0, if1.taken_cnt}, 32'd3);

    // asynchronous reset in the middle of T4
    if1.run = 1'b1;
    for (int c = 0; c < 7; c++) step();
    chk("pre-reset T4", {16'd0, s1}, 32'h00008004);
    if1.run = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async strobes", {16'd0, s1}, 32'd0);
    chk("async busy", {31'd0, if1.busy}, 32'd0);
    chk("async cnt", {30'd0, if1.taken_cnt}, 32'd0);
    chk("async con_ff", {31'd0, if1.con_ff}, 32'd0);
    chk("async dut0 cnt", {16'd0, if0.taken_cnt}, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    step();
    chk("post-reset idle", {16'd0, s1}, 32'd0);
    if1.run = 1'b1;
    step();
    chk("post-reset T0", {16'd0, s1}, 32'h0000F000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
